// File: rtl/shift_frame_ctrl_pkg.sv
// ============================================================================
// Module      : shift_frame_ctrl_pkg
// Description : Shared constants and FSM state encoding for the serial frame
//               transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_frame_ctrl_pkg;

    // Default data bits per frame and divider width
    localparam int c_n_default    = 8;
    localparam int c_divw_default = 16;

    // Frame FSM encoding (2 bits)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/piso_shreg.sv
// ============================================================================
// Module      : piso_shreg
// Description : Parallel-in serial-out shift register, right shift, LSB out.
//               Load takes priority over shift.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_shreg #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         ld,
    input  logic         si,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         so
);

    logic [N-1:0] r_q;

    // Load a new word, or shift right with si entering at the MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= d;
        end else if (en) begin
            r_q <= {si, r_q[N-1:1]};
        end
    end

    assign q  = r_q;
    assign so = r_q[0];

endmodule

`default_nettype wire

// File: rtl/shift_frame_ctrl.sv
// ============================================================================
// Module      : shift_frame_ctrl
// Description : Serial frame transmitter: start bit (0), N data bits LSB
//               first, stop bit (1); each bit lasts latched div+1 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_frame_ctrl
    import shift_frame_ctrl_pkg::*;
#(
    parameter int N    = c_n_default,
    parameter int DIVW = c_divw_default
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic [DIVW-1:0] div,
    input  logic            tx_valid,
    input  logic [N-1:0]    tx_data,
    output logic            tx_ready,
    output logic            sout,
    output logic            busy,
    output logic            done
);

    localparam int            c_bw       = $clog2(N);
    localparam logic [c_bw-1:0] c_last_bit = c_bw'(N - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DIVW-1:0]   r_per_cnt;
    logic [DIVW-1:0]   r_div;
    logic [c_bw-1:0]   r_bit_cnt;
    logic              r_done;
    logic              w_done_nxt;
    logic              w_bit_end;
    logic              w_load;
    logic              w_shift;
    logic              w_tx_ready;
    logic              w_so;
    logic [N-1:0]      w_shreg_q_unused;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode, handshake, shift strobe and done request; clr overrides all
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_bit_end   = (r_per_cnt == '0);
        w_tx_ready  = (r_state == IDLE) && !clr && !rst;
        case (r_state)
            IDLE: begin
                if (tx_valid && w_tx_ready) begin
                    w_state_nxt = START;
                    w_load      = 1'b1;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == c_last_bit) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (clr) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b0;
            w_load      = 1'b0;
            w_shift     = 1'b0;
        end
    end

    // Period and bit counters; divider is latched only at the handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_per_cnt <= '0;
            r_bit_cnt <= '0;
            r_div     <= '0;
        end else if (clr) begin
            r_per_cnt <= '0;
            r_bit_cnt <= '0;
        end else if (w_load) begin
            r_div     <= div;
            r_per_cnt <= div;
            r_bit_cnt <= '0;
        end else if (r_state != IDLE) begin
            if (w_bit_end) begin
                r_per_cnt <= r_div;
                if (r_state == DATA) begin
                    r_bit_cnt <= (r_bit_cnt == c_last_bit) ? '0 : r_bit_cnt + c_bw'(1);
                end
            end else begin
                r_per_cnt <= r_per_cnt - DIVW'(1);
            end
        end
    end

    // Done pulse for the first IDLE cycle after a completed frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
        end
    end

    piso_shreg #(
        .N (N)
    ) u_shreg (
        .clk (clk),
        .rst (rst),
        .en  (w_shift),
        .ld  (w_load),
        .si  (1'b1),
        .d   (tx_data),
        .q   (w_shreg_q_unused),
        .so  (w_so)
    );

    // Serial line decoded from registered state and register contents only
    always_comb begin
        sout = 1'b1;
        case (r_state)
            START:   sout = 1'b0;
            DATA:    sout = w_so;
            default: sout = 1'b1;
        endcase
    end

    assign tx_ready = w_tx_ready;
    assign busy     = (r_state != IDLE);
    assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_shift_frame_ctrl.sv
// ============================================================================
// Module      : tb_shift_frame_ctrl
// Description : Self-checking bench for shift_frame_ctrl (N=8, DIVW=16)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_frame_ctrl;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [15:0] div;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        sout;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;
    int cyc;

    // Reference model: frame position counted from the handshake
    bit         m_busy;
    bit         m_done_now;
    bit         m_hs;
    int         m_k;
    int         m_div;
    logic [7:0] m_word;
    logic       e_sout, e_busy, e_done, e_rdy;

    shift_frame_ctrl #(
        .N    (8),
        .DIVW (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .div      (div),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .sout     (sout),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock cycle: drive inputs, compute expected outputs, advance model
    task automatic step(input logic r, input logic c, input logic v,
                        input logic [7:0] d, input logic [15:0] dv);
        int p;
        int slot;
        @(negedge clk);
        rst = r; clr = c; tx_valid = v; tx_data = d; div = dv;
        if (r) begin
            e_sout = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_rdy = 1'b0;
        end else if (!m_busy) begin
            e_sout = 1'b1; e_busy = 1'b0; e_done = m_done_now; e_rdy = !c;
        end else begin
            p    = m_div + 1;
            slot = (m_k - 1) / p;
            if (slot == 0)      e_sout = 1'b0;
            else if (slot <= 8) e_sout = m_word[slot-1];
            else                e_sout = 1'b1;
            e_busy = 1'b1; e_done = 1'b0; e_rdy = 1'b0;
        end
        #1;
        m_hs = 1'b0;
        if (r || c) begin
            m_busy = 1'b0; m_done_now = 1'b0;
        end else if (!m_busy) begin
            m_done_now = 1'b0;
            if (v) begin
                m_hs = 1'b1; m_busy = 1'b1; m_k = 1; m_word = d; m_div = int'(dv);
            end
        end else begin
            m_k++;
            if (m_k == 10 * (m_div + 1) + 1) begin
                m_busy = 1'b0; m_done_now = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'h33, 16'd2);
            vectors++;
            if ({sout, busy, done, tx_ready} !== {e_sout, e_busy, e_done, e_rdy}) begin
                miscompares++;
                $display("FAIL reset cyc=%0d got sout/busy/done/rdy=%b%b%b%b need %b%b%b%b",
                         cyc, sout, busy, done, tx_ready, e_sout, e_busy, e_done, e_rdy);
            end
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 16'd0);
        vectors++;
        if ({sout, busy, done, tx_ready} !== 4'b1001) begin
            miscompares++;
            $display("FAIL reset_release got sout/busy/done/rdy=%b%b%b%b need 1001",
                     sout, busy, done, tx_ready);
        end
    endtask

    task automatic test_frame_a5();
        int dn = -1;
        step(1'b0, 1'b0, 1'b1, 8'hA5, 16'd3);
        for (int i = 1; i <= 45; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'($urandom), 16'd3);
            vectors++;
            if ({sout, busy, done, tx_ready} !== {e_sout, e_busy, e_done, e_rdy}) begin
                miscompares++;
                $display("FAIL frame_a5 +%0d got sout/busy/done/rdy=%b%b%b%b need %b%b%b%b",
                         i, sout, busy, done, tx_ready, e_sout, e_busy, e_done, e_rdy);
            end
            if (done === 1'b1 && dn < 0) dn = i;
        end
        vectors++;
        if (dn !== 41) begin
            miscompares++;
            $display("FAIL frame_a5_latency got %0d need 41", dn);
        end
    endtask

    task automatic test_back_to_back();
        int d1 = -1;
        int d2 = -1;
        step(1'b0, 1'b0, 1'b1, 8'h00, 16'd0);
        for (int i = 1; i <= 24; i++) begin
            step(1'b0, 1'b0, (i < 22), 8'hFF, 16'd0);
            vectors++;
            if ({sout, busy, done, tx_ready} !== {e_sout, e_busy, e_done, e_rdy}) begin
                miscompares++;
                $display("FAIL back_to_back +%0d got sout/busy/done/rdy=%b%b%b%b need %b%b%b%b",
                         i, sout, busy, done, tx_ready, e_sout, e_busy, e_done, e_rdy);
            end
            if (done === 1'b1) begin
                if (d1 < 0) d1 = i;
                else if (d2 < 0) d2 = i;
            end
        end
        vectors++;
        if (d1 !== 11 || d2 !== 22) begin
            miscompares++;
            $display("FAIL back_to_back_done got %0d,%0d need 11,22", d1, d2);
        end
    endtask

    task automatic test_div_change();
        step(1'b0, 1'b0, 1'b1, 8'h3C, 16'd3);
        for (int i = 1; i <= 55; i++) begin
            step(1'b0, 1'b0, (i == 41), 8'h3C, (i >= 10) ? 16'd0 : 16'd3);
            vectors++;
            if ({sout, busy, done, tx_ready} !== {e_sout, e_busy, e_done, e_rdy}) begin
                miscompares++;
                $display("FAIL div_change +%0d got sout/busy/done/rdy=%b%b%b%b need %b%b%b%b",
                         i, sout, busy, done, tx_ready, e_sout, e_busy, e_done, e_rdy);
            end
        end
    endtask

    task automatic test_clr_abort();
        step(1'b0, 1'b0, 1'b1, 8'($urandom), 16'd1);
        for (int i = 1; i <= 35; i++) begin
            step(1'b0, (i == 7 || i == 8), (i >= 7 && i <= 9), 8'($urandom), 16'd1);
            vectors++;
            if ({sout, busy, done, tx_ready} !== {e_sout, e_busy, e_done, e_rdy}) begin
                miscompares++;
                $display("FAIL clr_abort +%0d got sout/busy/done/rdy=%b%b%b%b need %b%b%b%b",
                         i, sout, busy, done, tx_ready, e_sout, e_busy, e_done, e_rdy);
            end
            if (i == 9 && m_hs !== 1'b1) begin
                miscompares++;
                $display("FAIL clr_accept model saw no handshake after clr dropped");
            end
        end
    endtask

    task automatic test_rst_mid_stop();
        step(1'b0, 1'b0, 1'b1, 8'($urandom), 16'd2);
        for (int i = 1; i <= 58; i++) begin
            step((i == 29 || i == 30), 1'b0, (i == 32), (i == 32) ? 8'h5A : 8'($urandom),
                 (i == 32) ? 16'd1 : 16'd2);
            vectors++;
            if ({sout, busy, done, tx_ready} !== {e_sout, e_busy, e_done, e_rdy}) begin
                miscompares++;
                $display("FAIL rst_mid_stop +%0d got sout/busy/done/rdy=%b%b%b%b need %b%b%b%b",
                         i, sout, busy, done, tx_ready, e_sout, e_busy, e_done, e_rdy);
            end
        end
    endtask

    task automatic test_valid_toggle();
        step(1'b0, 1'b0, 1'b1, 8'($urandom), 16'd1);
        for (int i = 1; i <= 60; i++) begin
            step(1'b0, 1'b0, (i < 20) ? 1'($urandom) : 1'b0, 8'($urandom), 16'd1);
            vectors++;
            if ({sout, busy, done, tx_ready} !== {e_sout, e_busy, e_done, e_rdy}) begin
                miscompares++;
                $display("FAIL valid_toggle +%0d got sout/busy/done/rdy=%b%b%b%b need %b%b%b%b",
                         i, sout, busy, done, tx_ready, e_sout, e_busy, e_done, e_rdy);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0), 1'($urandom),
                 8'($urandom), 16'($urandom_range(0, 3)));
            vectors++;
            if ({sout, busy, done, tx_ready} !== {e_sout, e_busy, e_done, e_rdy}) begin
                miscompares++;
                $display("FAIL random cyc=%0d got sout/busy/done/rdy=%b%b%b%b need %b%b%b%b",
                         cyc, sout, busy, done, tx_ready, e_sout, e_busy, e_done, e_rdy);
            end
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; div = '0; tx_valid = 1'b0; tx_data = '0;
        vectors = 0; miscompares = 0; cyc = 0;
        m_busy = 1'b0; m_done_now = 1'b0; m_hs = 1'b0; m_k = 0; m_div = 0; m_word = '0;
        test_reset();
        test_frame_a5();
        test_back_to_back();
        test_div_change();
        test_clr_abort();
        test_rst_mid_stop();
        test_valid_toggle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
